// File: rtl/mouse_bus_interface_pkg.sv
// mouse_bus_interface_pkg
//   Shared definitions for the mouse bus interface and its event FIFO:
//   register offsets inside the 8-byte window, event entry layout/width,
//   FLAGS bit positions and a helper that assembles the FLAGS byte.
package mouse_bus_interface_pkg;

  localparam int EntryW = 28;

  localparam logic [2:0] OFS_STATUS = 3'd0;
  localparam logic [2:0] OFS_X      = 3'd1;
  localparam logic [2:0] OFS_Y      = 3'd2;
  localparam logic [2:0] OFS_Z      = 3'd3;
  localparam logic [2:0] OFS_FLAGS  = 3'd4;
  localparam logic [2:0] OFS_POP    = 3'd5;
  localparam logic [2:0] OFS_CTRL   = 3'd6;
  localparam logic [2:0] OFS_DROP   = 3'd7;

  localparam int FLAG_EMPTY     = 0;
  localparam int FLAG_FULL      = 1;
  localparam int FLAG_OVF       = 2;
  localparam int FLAG_COUNT_LSB = 4;

  // One captured mouse update, packed as {status, X, Y, Z}.
  typedef struct packed {
    logic [3:0] status;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } mouseEvent_t;

  // FLAGS = {count[3:0], 1'b0, ovf, full, empty}
  function automatic logic [7:0] packFlags(input logic [3:0] count, input logic ovf,
                                           input logic full, input logic empty);
    logic [7:0] flags;
    flags = 8'h00;
    flags[FLAG_COUNT_LSB +: 4] = count;
    flags[FLAG_OVF]            = ovf;
    flags[FLAG_FULL]           = full;
    flags[FLAG_EMPTY]          = empty;
    return flags;
  endfunction

endpackage

// File: rtl/mouse_bus_interface_fifo.sv
// mouse_event_fifo
//   Synchronous FIFO with first-word-fall-through head. A push while full is
//   accepted only when a pop happens in the same cycle (the pop frees the slot).
// Ports:
//   CLK, RESET          clock, synchronous active-high reset (empties the FIFO)
//   push, pushData      write request and entry
//   pop                 advance head (ignored when empty)
//   head                current head entry (stale when empty)
//   full, empty, count  occupancy status
//   pushAccepted        push request that was stored this cycle
//   pushDropped         push request that was discarded (full, no pop)
module mouse_event_fifo #(
  parameter int Depth = 4,
  parameter int Width = 28
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [Width-1:0]           pushData,
  input  logic                       pop,
  output logic [Width-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count,
  output logic                       pushAccepted,
  output logic                       pushDropped
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0]   FullCount = (AW+1)'(Depth);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [Width-1:0] mem_r [Depth];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [AW:0]      count_r;
  logic             popAccepted_s;

  assign full          = (count_r == FullCount);
  assign empty         = (count_r == '0);
  assign count         = count_r;
  assign head          = mem_r[rdPtr_r];
  assign popAccepted_s = pop && !empty;
  // A pop frees the slot in the same edge, so push+pop on a full FIFO is legal.
  assign pushAccepted  = push && (!full || pop);
  assign pushDropped   = push && full && !pop;

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge CLK) begin
    if (pushAccepted) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since Depth is a power of 2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (pushAccepted) wrPtr_r <= wrPtr_r + PtrOne;
      if (popAccepted_s) rdPtr_r <= rdPtr_r + PtrOne;
      case ({pushAccepted, popAccepted_s})
        2'b10:   count_r <= count_r + CountOne;
        2'b01:   count_r <= count_r - CountOne;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mouse_bus_interface.sv
// mouse_bus_interface
//   Captures mouse updates into an event FIFO and exposes it on the 8-bit
//   processor bus at BaseAddr..BaseAddr+7; raises a level interrupt per
//   accepted event until acknowledged.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   MOUSE_STATUS/X/Y/Z          event fields, captured on MOUSE_INTERRUPT
//   MOUSE_INTERRUPT             one-cycle "new event" pulse
//   BUS_ADDR, BUS_WE            processor address and write strobe
//   BUS_DATA                    bidirectional data; driven the cycle after a read
//   INTERRUPT_RAISE/ACK         interrupt request and acknowledge
module mouse_bus_interface
  import mouse_bus_interface_pkg::*;
#(
  parameter logic [7:0] BaseAddr  = 8'hA0,
  parameter int         FifoDepth = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic [7:0] MOUSE_Z,
  input  logic       MOUSE_INTERRUPT,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       INTERRUPT_RAISE,
  input  logic       INTERRUPT_ACK
);

  localparam int CountW = $clog2(FifoDepth) + 1;

  logic [8:0]        addrDiff_s;
  logic              hit_s;
  logic [2:0]        offset_s;
  logic              readReq_s;
  logic              popReq_s;
  logic              ctrlWr_s;
  logic              dropClr_s;
  mouseEvent_t       pushEntry_s;
  mouseEvent_t       headEv_s;
  logic              full_s;
  logic              empty_s;
  logic [CountW-1:0] count_s;
  logic [3:0]        countNib_s;
  logic              pushAccepted_s;
  logic              pushDropped_s;
  logic [7:0]        readMux_s;
  logic [7:0]        readData_r;
  logic              readValid_r;
  logic              irqEn_r;
  logic [7:0]        dropCount_r;
  logic              ovf_r;
  logic              irq_r;
  logic              unusedBusBits_s;

  // Window check by subtraction so BaseAddr need not be 8-aligned; a borrow
  // (address below base) lands in bit 8 and fails the hit test.
  assign addrDiff_s = {1'b0, BUS_ADDR} - {1'b0, BaseAddr};
  assign hit_s      = (addrDiff_s[8:3] == 6'd0);
  assign offset_s   = addrDiff_s[2:0];
  assign readReq_s  = hit_s && !BUS_WE;
  assign popReq_s   = hit_s && BUS_WE && (offset_s == OFS_POP);
  assign ctrlWr_s   = hit_s && BUS_WE && (offset_s == OFS_CTRL);
  assign dropClr_s  = hit_s && BUS_WE && (offset_s == OFS_DROP);

  assign pushEntry_s     = {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z};
  assign countNib_s      = 4'(count_s);
  assign unusedBusBits_s = ^BUS_DATA[7:1];

  mouse_event_fifo #(
    .Depth (FifoDepth),
    .Width (EntryW)
  ) u_fifo (
    .CLK          (CLK),
    .RESET        (RESET),
    .push         (MOUSE_INTERRUPT),
    .pushData     (pushEntry_s),
    .pop          (popReq_s),
    .head         (headEv_s),
    .full         (full_s),
    .empty        (empty_s),
    .count        (count_s),
    .pushAccepted (pushAccepted_s),
    .pushDropped  (pushDropped_s)
  );

  // Register read mux; head fields read zero when no entry is present.
  always_comb begin
    readMux_s = 8'h00;
    case (offset_s)
      OFS_STATUS: readMux_s = empty_s ? 8'h00 : {4'h0, headEv_s.status};
      OFS_X:      readMux_s = empty_s ? 8'h00 : headEv_s.x;
      OFS_Y:      readMux_s = empty_s ? 8'h00 : headEv_s.y;
      OFS_Z:      readMux_s = empty_s ? 8'h00 : headEv_s.z;
      OFS_FLAGS:  readMux_s = packFlags(countNib_s, ovf_r, full_s, empty_s);
      OFS_CTRL:   readMux_s = {7'h00, irqEn_r};
      OFS_DROP:   readMux_s = dropCount_r;
      default:    readMux_s = 8'h00;
    endcase
  end

  // Read data is captured in the address cycle and driven for the next cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      readValid_r <= 1'b0;
      readData_r  <= 8'h00;
    end else begin
      readValid_r <= readReq_s;
      readData_r  <= readMux_s;
    end
  end

  assign BUS_DATA = readValid_r ? readData_r : 8'hzz;

  // CTRL, saturating drop counter and sticky overflow; a clear beats a drop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irqEn_r     <= 1'b1;
      dropCount_r <= 8'h00;
      ovf_r       <= 1'b0;
    end else begin
      if (ctrlWr_s) irqEn_r <= BUS_DATA[0];
      if (dropClr_s) begin
        dropCount_r <= 8'h00;
        ovf_r       <= 1'b0;
      end else if (pushDropped_s) begin
        if (dropCount_r != 8'hFF) dropCount_r <= dropCount_r + 8'h01;
        ovf_r <= 1'b1;
      end
    end
  end

  // Interrupt request: a new accepted event wins over a coincident ACK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_r <= 1'b0;
    end else if (pushAccepted_s && irqEn_r) begin
      irq_r <= 1'b1;
    end else if (INTERRUPT_ACK) begin
      irq_r <= 1'b0;
    end
  end

  assign INTERRUPT_RAISE = irq_r;

endmodule
